// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the bit-serial front-end blocks.
//   state_t : shifter control state (IDLE waits for a word, SHIFT emits bits)
//   cnt_w() : bit-counter width for a given word width, never below 1 bit
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must index WIDTH-1 down to 0; a 1-bit word still needs a 1-bit counter.
  function automatic int cnt_w(input int width);
    int c;
    c = $clog2(width);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// serial_word_shifter: parallel-to-serial converter feeding bit-serial detectors.
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit per
// transfer, MSB-first (MSB_FIRST=1) or LSB-first (MSB_FIRST=0).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din, din_valid    parallel word and its valid strobe
//   din_ready         word can be accepted this cycle (combinational on ser_ready)
//   ser_out           current serial bit
//   ser_valid         ser_out is valid
//   ser_ready         downstream takes ser_out this cycle
//   ser_first         ser_out is the first bit of the word in transmit order
//   ser_last          ser_out is the final bit of the word
//   busy              a word is in flight
module serial_word_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             first_r, first_s;
  logic             din_ready_s;
  logic             accept_s;
  logic             xfer_s;
  logic             cnt_zero_s;

  // Handshake decode; din_ready is the only path from an input to an output.
  always_comb begin
    cnt_zero_s  = (cnt_r == CNT_ZERO);
    din_ready_s = (state_r == IDLE) ||
                  ((state_r == SHIFT) && cnt_zero_s && ser_ready);
    accept_s    = din_valid && din_ready_s;
    xfer_s      = (state_r == SHIFT) && ser_ready;
  end

  // Next-state logic: load on accept, shift on transfer, hold on stall.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    first_s = first_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SHIFT;
          shreg_s = din;
          cnt_s   = CNT_LOAD;
          first_s = 1'b1;
        end else begin
          first_s = 1'b0;
        end
      end
      SHIFT: begin
        if (xfer_s && !cnt_zero_s) begin
          shreg_s = MSB_FIRST ? (shreg_r << 1'b1) : (shreg_r >> 1'b1);
          cnt_s   = cnt_r - CNT_ONE;
          first_s = 1'b0;
        end else if (xfer_s && accept_s) begin
          // Last bit leaves while the next word loads: no bubble.
          shreg_s = din;
          cnt_s   = CNT_LOAD;
          first_s = 1'b1;
        end else if (xfer_s) begin
          state_s = IDLE;
          first_s = 1'b0;
        end else begin
          state_s = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
        shreg_s = '0;
        cnt_s   = CNT_ZERO;
        first_s = 1'b0;
      end
    endcase
  end

  // State, shift register, counter and first-bit flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shreg_r <= '0;
      cnt_r   <= CNT_ZERO;
      first_r <= 1'b0;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      first_r <= first_s;
    end
  end

  assign din_ready = din_ready_s;
  assign ser_out   = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
  assign ser_valid = (state_r == SHIFT);
  assign busy      = (state_r == SHIFT);
  assign ser_first = first_r && (state_r == SHIFT);
  assign ser_last  = (state_r == SHIFT) && cnt_zero_s;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: three instances (8-bit MSB-first, 8-bit
// LSB-first, 1-bit). Each has a queue model of the bits still owed downstream;
// directed scenarios pin the model with literal streams, then random traffic.
module tb_serial_word_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din_a       [3];
  logic       din_valid_a [3];
  logic       din_ready_a [3];
  logic       ser_out_a   [3];
  logic       ser_valid_a [3];
  logic       ser_ready_a [3];
  logic       ser_first_a [3];
  logic       ser_last_a  [3];
  logic       busy_a      [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_inst
      localparam int W = (k == 2) ? 1 : 8;
      localparam bit M = (k == 1) ? 1'b0 : 1'b1;

      serial_word_shifter #(.WIDTH(W), .MSB_FIRST(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a[k][W-1:0]),
        .din_valid (din_valid_a[k]),
        .din_ready (din_ready_a[k]),
        .ser_out   (ser_out_a[k]),
        .ser_valid (ser_valid_a[k]),
        .ser_ready (ser_ready_a[k]),
        .ser_first (ser_first_a[k]),
        .ser_last  (ser_last_a[k]),
        .busy      (busy_a[k])
      );

      // Bits owed downstream, head = bit on the wire: {bit, first, last}.
      logic [2:0] q [$];

      always @(posedge clk) begin : model
        bit rdy;
        if (rst) begin
          q.delete();
        end else begin
          rdy = (q.size() == 0) || (q.size() == 1 && ser_ready_a[k]);
          if (q.size() != 0 && ser_ready_a[k]) void'(q.pop_front());
          if (din_valid_a[k] && rdy) begin
            for (int i = 0; i < W; i++)
              q.push_back({din_a[k][M ? (W - 1 - i) : i], 1'(i == 0), 1'(i == W - 1)});
          end
        end
      end

      always @(negedge clk) begin : compare
        if (chk_en) begin
          check($sformatf("i%0d ser_valid", k), 32'(ser_valid_a[k]), 32'(q.size() != 0));
          check($sformatf("i%0d busy", k), 32'(busy_a[k]), 32'(q.size() != 0));
          check($sformatf("i%0d din_ready", k), 32'(din_ready_a[k]),
                32'((q.size() == 0) || (q.size() == 1 && ser_ready_a[k])));
          if (q.size() != 0) begin
            check($sformatf("i%0d ser_out", k), 32'(ser_out_a[k]), 32'(q[0][2]));
            check($sformatf("i%0d ser_first", k), 32'(ser_first_a[k]), 32'(q[0][1]));
            check($sformatf("i%0d ser_last", k), 32'(ser_last_a[k]), 32'(q[0][0]));
          end
        end
      end
    end
  endgenerate

  // Stream capture for the directed scenarios, on one selected instance.
  int          cap_sel = 0;
  logic [31:0] capv;
  int          ncap, nvalid, nfirst, nlast;

  always @(negedge clk) begin
    if (!rst && ser_valid_a[cap_sel]) begin
      nvalid++;
      if (ser_ready_a[cap_sel]) begin
        capv = {capv[30:0], ser_out_a[cap_sel]};
        ncap++;
        if (ser_first_a[cap_sel]) nfirst++;
        if (ser_last_a[cap_sel]) nlast++;
      end
    end
  end

  task automatic clear_cap();
    capv = 32'd0; ncap = 0; nvalid = 0; nfirst = 0; nlast = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Present a word and hold it until accepted; returns 2 time units after the accept edge.
  task automatic send(input int idx, input logic [7:0] w);
    din_a[idx] = w;
    din_valid_a[idx] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (din_ready_a[idx]) begin
        @(posedge clk);
        #2;
        din_valid_a[idx] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send timeout: instance %0d word %0h not accepted within 40 cycles", idx, w);
    din_valid_a[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_a[i] = 8'h00; din_valid_a[i] = 1'b0; ser_ready_a[i] = 1'b1;
    end
    clear_cap();
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    check("reset ser_out", 32'(ser_out_a[0]), 32'd0);
    check("reset ser_valid", 32'(ser_valid_a[0]), 32'd0);
    check("reset ser_first", 32'(ser_first_a[0]), 32'd0);
    check("reset ser_last", 32'(ser_last_a[0]), 32'd0);
    check("reset busy", 32'(busy_a[0]), 32'd0);
    check("reset din_ready", 32'(din_ready_a[0]), 32'd1);
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(2);

    // 1: single MSB-first word.
    clear_cap();
    send(0, 8'hA5);
    check("t1 first after accept", 32'(ser_first_a[0]), 32'd1);
    check("t1 din_ready low", 32'(din_ready_a[0]), 32'd0);
    wait_cycles(10);
    check("t1 stream", capv & 32'hFF, 32'h000000A5);
    check("t1 bits", 32'(ncap), 32'd8);
    check("t1 valid cycles", 32'(nvalid), 32'd8);
    check("t1 firsts", 32'(nfirst), 32'd1);
    check("t1 lasts", 32'(nlast), 32'd1);

    // 2: back-to-back words.
    clear_cap();
    send(0, 8'h0F);
    send(0, 8'hF0);
    wait_cycles(18);
    check("t2 stream", capv & 32'hFFFF, 32'h00000FF0);
    check("t2 valid cycles", 32'(nvalid), 32'd16);
    check("t2 firsts", 32'(nfirst), 32'd2);
    check("t2 lasts", 32'(nlast), 32'd2);

    // 3: three-cycle stall starting on the third bit.
    clear_cap();
    send(0, 8'hC3);
    wait_cycles(2);
    ser_ready_a[0] = 1'b0;
    wait_cycles(3);
    ser_ready_a[0] = 1'b1;
    wait_cycles(10);
    check("t3 stream", capv & 32'hFF, 32'h000000C3);
    check("t3 bits", 32'(ncap), 32'd8);
    check("t3 valid cycles", 32'(nvalid), 32'd11);
    check("t3 lasts", 32'(nlast), 32'd1);

    // 4: reset mid-word, then a fresh word.
    send(0, 8'hFF);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("t4 ser_valid after rst", 32'(ser_valid_a[0]), 32'd0);
    check("t4 busy after rst", 32'(busy_a[0]), 32'd0);
    check("t4 din_ready after rst", 32'(din_ready_a[0]), 32'd1);
    clear_cap();
    send(0, 8'h01);
    check("t4 first after accept", 32'(ser_first_a[0]), 32'd1);
    wait_cycles(10);
    check("t4 stream", capv & 32'hFF, 32'h00000001);
    check("t4 bits", 32'(ncap), 32'd8);
    check("t4 firsts", 32'(nfirst), 32'd1);

    // 5: LSB-first instance.
    cap_sel = 1;
    clear_cap();
    send(1, 8'h01);
    wait_cycles(10);
    check("t5 stream", capv & 32'hFF, 32'h00000080);
    check("t5 bits", 32'(ncap), 32'd8);
    check("t5 lasts", 32'(nlast), 32'd1);

    // 6: 1-bit words back to back.
    cap_sel = 2;
    clear_cap();
    send(2, 8'h01);
    send(2, 8'h00);
    send(2, 8'h01);
    wait_cycles(4);
    check("t6 stream", capv & 32'h7, 32'h00000005);
    check("t6 valid cycles", 32'(nvalid), 32'd3);
    check("t6 firsts", 32'(nfirst), 32'd3);
    check("t6 lasts", 32'(nlast), 32'd3);

    // Random traffic on all instances, with occasional resets.
    cap_sel = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        din_a[i]       = 8'($urandom);
        din_valid_a[i] = ($urandom_range(0, 3) != 0);
        ser_ready_a[i] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      wait_cycles(1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_valid_a[i] = 1'b0; ser_ready_a[i] = 1'b1;
    end
    wait_cycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
